sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the 16x8 dual-port RAM.
- It turns a push/pop streaming interface into RAM write/read strobes and addresses.
- It returns RAM read data to the consumer with a valid qualifier.
- Storage is entirely in the external RAM; this block holds only pointers, occupancy and flags.

Parameters:
- DATA_WIDTH, 8, width of data words; must match the RAM width.
- DEPTH, 16, number of entries; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 4, RAM address width; pointers are ADDR_SIZE+1 bits, including the wrap bit.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write request from the producer.
- din  in  DATA_WIDTH  write data from the producer.
- pop  in  1  read request from the consumer.
- dout  out  DATA_WIDTH  read data; equals ram_rd_data (RAM output register), passed straight through.
- dout_valid  out  1  high the cycle after an accepted pop.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH.
- ram_write  out  1  RAM write strobe.
- ram_wr_addr  out  ADDR_SIZE  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_read  out  1  RAM read strobe.
- ram_rd_addr  out  ADDR_SIZE  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM registered read data (1-cycle latency).

Behaviour:
- Reset: wr_ptr=0, rd_ptr=0, count=0, dout_valid=0, empty=1, full=0. Reset overrides push/pop in the same cycle. The RAM is reset by the same rst.
- Accept rules: push_ok = push & (~full | pop_ok); pop_ok = pop & ~empty. Evaluate pop_ok first.
- RAM strobes and addresses are combinational:
  - ram_write = push_ok; ram_wr_addr = wr_ptr[ADDR_SIZE-1:0]; ram_wr_data = din.
  - ram_read = pop_ok; ram_rd_addr = rd_ptr[ADDR_SIZE-1:0].
- Pointer update per edge:
  - wr_ptr += push_ok; rd_ptr += pop_ok. Both wrap modulo 2*DEPTH; address bits wrap modulo DEPTH.
  - count += push_ok - pop_ok.
- Flags are registered from the next-state count. full and empty are never both high.
- Read latency: pop accepted in cycle N → dout_valid=1 and dout valid in cycle N+1. dout_valid is otherwise 0.
- Empty + push + pop: pop is rejected (no fall-through); push is accepted; count goes 0→1.
- Full + push + pop: both are accepted and count stays at DEPTH. Read and write address are equal; the RAM returns the old (oldest) word, which is the required result.
- Full + push only: push is dropped; pointers and count unchanged; no RAM write.
- Empty + pop only: pop is dropped; dout_valid=0 next cycle.
- Reset mid-operation: all contents are discarded. dout_valid=0 in the cycle after reset even if a pop was pending.

Optional Feature:
- Macro: SYNC_FIFO_CTRL_ERR_FLAGS_EN.
- Enabled: adds outputs overflow and underflow, each 1 bit, sticky, reset to 0.
  - overflow sets on push & full & ~pop.
  - underflow sets on pop & empty.
  - Both are cleared only by rst.
- Disabled: these ports and registers are absent; dropped requests are silent.

Test Plan:
- Reset, then 16 pushes of 0x00..0x0F with no pops → full=1, count=16, ram_wr_addr sequence 0..15, empty=0.
- From full, 16 pops → dout 0x00..0x0F, each one cycle after its pop with dout_valid=1; then empty=1, count=0.
- Fill 10, pop 10, push 12 (0xA0..0xAB), pop 12 → addresses wrap 10..15,0..5; output order 0xA0..0xAB intact.
- Full, then push 0x55 with pop in the same cycle → dout=oldest word, count stays 16, 0x55 is read out last.
- Empty, push 0x3C with pop in the same cycle → no dout_valid; count=1; next pop returns 0x3C.
- Push on full and pop on empty → no pointer change. With SYNC_FIFO_CTRL_ERR_FLAGS_EN, overflow=1 and underflow=1, both held until rst.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller that drives an external 16x8 dual-port RAM with a registered read port.
// Define SYNC_FIFO_CTRL_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_SIZE:0]    count,
  output logic                  ram_write,
  output logic [ADDR_SIZE-1:0]  ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_read,
  output logic [ADDR_SIZE-1:0]  ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_SIZE:0] PTR_ONE   = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE+1)'(DEPTH);

  logic [ADDR_SIZE:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_SIZE:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_SIZE:0] count_reg, count_next;
  logic               full_reg, empty_reg;
  logic               dout_valid_reg;
  logic               push_ok, pop_ok;

  // A pop frees a slot in the same cycle, so a push on full is allowed alongside it.
  assign pop_ok  = pop & ~empty_reg;
  assign push_ok = push & (~full_reg | pop_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + PTR_ONE;
      2'b01:   count_next = count_reg - PTR_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
      dout_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      full_reg       <= (count_next == DEPTH_CNT);
      empty_reg      <= (count_next == '0);
      dout_valid_reg <= pop_ok;
    end
  end

  assign ram_write   = push_ok;
  assign ram_wr_addr = wr_ptr_reg[ADDR_SIZE-1:0];
  assign ram_wr_data = din;
  assign ram_read    = pop_ok;
  assign ram_rd_addr = rd_ptr_reg[ADDR_SIZE-1:0];

  assign dout       = ram_rd_data;
  assign dout_valid = dout_valid_reg;
  assign full       = full_reg;
  assign empty      = empty_reg;
  assign count      = count_reg;

`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push & full_reg & ~pop) overflow_reg  <= 1'b1;
      if (pop & empty_reg)        underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed scenarios plus random traffic against a queue model.
// Covers the SYNC_FIFO_CTRL_ERR_FLAGS_EN outputs when that macro is defined.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [7:0] din = '0;
  logic       pop = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, full, empty;
  logic [4:0] count;
  logic       ram_write, ram_read;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_wr_data, ram_rd_data;
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_SIZE(4)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty), .count(count),
    .ram_write(ram_write), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_read(ram_read), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  // External 16x8 RAM: read-before-write, registered output, cleared by rst.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      ram_rd_data <= '0;
    end else begin
      if (ram_read)  ram_rd_data <= mem[ram_rd_addr];
      if (ram_write) mem[ram_wr_addr] <= ram_wr_data;
    end
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_txn    = 0;
  logic [7:0] model_q[$];
  int         n_push_acc = 0;
  int         n_pop_acc  = 0;
  bit         m_ovf = 0;
  bit         m_udf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(model_q.size()));
    check("full",  32'(full),  32'(model_q.size() == 16));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
`endif
  endtask

  task automatic step(input logic p, input logic [7:0] d, input logic q);
    bit         pok, wok;
    logic [7:0] exp_d;
    exp_d = '0;
    @(negedge clk);
    push = p; din = d; pop = q;
    #1;
    pok = q && (model_q.size() > 0);
    wok = p && ((model_q.size() < 16) || pok);
    check("ram_write", 32'(ram_write), 32'(wok));
    check("ram_read",  32'(ram_read),  32'(pok));
    if (wok) begin
      check("ram_wr_addr", 32'(ram_wr_addr), 32'(n_push_acc % 16));
      check("ram_wr_data", 32'(ram_wr_data), 32'(d));
    end
    if (pok) check("ram_rd_addr", 32'(ram_rd_addr), 32'(n_pop_acc % 16));
    if (p && model_q.size() == 16 && !q) m_ovf = 1;
    if (q && model_q.size() == 0)        m_udf = 1;
    if (pok) begin
      exp_d = model_q.pop_front();
      n_pop_acc++;
    end
    if (wok) begin
      model_q.push_back(d);
      n_push_acc++;
    end
    @(posedge clk);
    #1;
    check("dout_valid", 32'(dout_valid), 32'(pok));
    if (pok) check("dout", 32'(dout), 32'(exp_d));
    check_state();
    $display("txn %0d push=%0b din=%02h pop=%0b -> count=%0d dout_valid=%0b dout=%02h",
             n_txn, p, d, q, count, dout_valid, dout);
    n_txn++;
  endtask

  task automatic do_reset(input logic p, input logic q);
    @(negedge clk);
    rst = 1'b1; push = p; pop = q; din = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    n_push_acc = 0; n_pop_acc = 0;
    m_ovf = 0; m_udf = 0;
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check_state();
    $display("txn %0d reset push=%0b pop=%0b -> count=%0d", n_txn, p, q, count);
    n_txn++;
  endtask

  initial begin
    // Reset overrides simultaneous requests.
    do_reset(1'b1, 1'b1);

    // Fill with 0x00..0x0F, then drain.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // Address wraparound: fill 10, drain 10, push 12, drain 12.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);

    // Full with simultaneous push/pop: oldest word out, 0x55 comes out last.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // Empty with simultaneous push/pop: no fall-through.
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Dropped requests: push on full, pop on empty; sticky flags persist.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Reset with a pop pending on a non-empty FIFO.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset(1'b0, 1'b1);

    // Random traffic with a drifting push/pop bias and occasional resets.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        step(1'($urandom_range(0, 99) < bias),
             8'($urandom_range(0, 255)),
             1'($urandom_range(0, 99) < (100 - bias)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
